// File: rtl/noc_link_rx_pkg.sv
// Shared types and defaults for the NoC link receiver slice.
package noc_link_pkg;

  localparam int unsigned FLIT_WIDTH = 64;
  localparam int unsigned DEST_WIDTH = 4;

  typedef struct packed {
    logic                  is_tail;
    logic [DEST_WIDTH-1:0] dest;
    logic [FLIT_WIDTH-1:0] data;
  } flit_t;

  // Pointer width that stays at least one bit for a single-entry buffer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/noc_link_rx_if.sv
// Flit link input plus AXI-Stream output of the link receiver.
interface noc_link_rx_if #(
  parameter int unsigned FLIT_WIDTH = noc_link_pkg::FLIT_WIDTH,
  parameter int unsigned DEST_WIDTH = noc_link_pkg::DEST_WIDTH
);

  logic [FLIT_WIDTH-1:0] data_in;
  logic [DEST_WIDTH-1:0] dest_in;
  logic                  is_tail_in;
  logic                  send_in;
  logic                  credit_out;
  logic                  axis_out_tvalid;
  logic                  axis_out_tready;
  logic [FLIT_WIDTH-1:0] axis_out_tdata;
  logic                  axis_out_tlast;
  logic [DEST_WIDTH-1:0] axis_out_tdest;

  modport slave (
    input  data_in, dest_in, is_tail_in, send_in, axis_out_tready,
    output credit_out, axis_out_tvalid, axis_out_tdata, axis_out_tlast, axis_out_tdest
  );

  modport master (
    output data_in, dest_in, is_tail_in, send_in, axis_out_tready,
    input  credit_out, axis_out_tvalid, axis_out_tdata, axis_out_tlast, axis_out_tdest
  );

endinterface

// File: rtl/noc_link_rx_flit_fifo.sv
// Synchronous flit FIFO; a push into a full buffer is accepted only alongside a pop.
module flit_fifo
  import noc_link_pkg::*;
#(
  parameter int unsigned WIDTH      = $bits(flit_t),
  parameter int unsigned DEPTH      = 2,
  parameter bit          FORCE_MLAB = 1'b0,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_cnt == CNT_W'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_count   = r_cnt;
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Deep buffers can be steered into MLAB; shallow ones stay in registers.
  if (FORCE_MLAB && DEPTH >= 8) begin : g_mlab
    (* ramstyle = "MLAB, no_rw_check" *) logic [WIDTH-1:0] r_mem [DEPTH];
    always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    end
    assign o_rdata = r_mem[r_rd_ptr];
  end else begin : g_reg
    logic [WIDTH-1:0] r_mem [DEPTH];
    always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    end
    assign o_rdata = r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/noc_link_rx.sv
// Credit-returning link terminator: buffers flits, drains them as AXI-Stream,
// returns one credit per drained flit and counts delivered packets.
module noc_link_rx #(
  parameter int unsigned FLIT_WIDTH        = noc_link_pkg::FLIT_WIDTH,
  parameter int unsigned DEST_WIDTH        = noc_link_pkg::DEST_WIDTH,
  parameter int unsigned FLIT_BUFFER_DEPTH = 2,
  parameter int unsigned PKT_CNT_WIDTH     = 16,
  parameter bit          ROUTER_FORCE_MLAB = 1'b0
) (
  input  logic                     clk_noc,
  input  logic                     rst_noc_sync,
  noc_link_rx_if.slave             link,
  output logic                     overflow_err,
  output logic [PKT_CNT_WIDTH-1:0] pkt_count
);

  import noc_link_pkg::*;

  localparam int unsigned ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam int unsigned CNT_W   = $clog2(FLIT_BUFFER_DEPTH + 1);

  logic [ENTRY_W-1:0]       w_wdata;
  logic [ENTRY_W-1:0]       w_rdata;
  logic                     w_full;
  logic                     w_empty;
  logic [CNT_W-1:0]         w_count;
  logic                     w_pop;
  logic                     w_drop;
  logic                     r_credit;
  logic                     r_overflow;
  logic [PKT_CNT_WIDTH-1:0] r_pkt_count;

  // Entry layout matches flit_t: {is_tail, dest, data}.
  assign w_wdata = {link.is_tail_in, link.dest_in, link.data_in};
  assign w_pop   = link.axis_out_tready && !w_empty;
  assign w_drop  = link.send_in && w_full && !w_pop;

  flit_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH      (FLIT_BUFFER_DEPTH),
    .FORCE_MLAB (ROUTER_FORCE_MLAB)
  ) u_fifo (
    .clk     (clk_noc),
    .rst     (rst_noc_sync),
    .i_push  (link.send_in),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign link.axis_out_tvalid = (w_count != '0);
  assign link.axis_out_tdata  = w_rdata[FLIT_WIDTH-1:0];
  assign link.axis_out_tdest  = w_rdata[FLIT_WIDTH +: DEST_WIDTH];
  assign link.axis_out_tlast  = w_rdata[ENTRY_W-1];
  assign link.credit_out      = r_credit;
  assign overflow_err         = r_overflow;
  assign pkt_count            = r_pkt_count;

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      r_credit    <= 1'b0;
      r_overflow  <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_credit <= w_pop;
      if (w_drop) r_overflow <= 1'b1;
      if (w_pop && w_rdata[ENTRY_W-1]) r_pkt_count <= r_pkt_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_link_rx.sv
// Directed and credit-obeying streaming checks for noc_link_rx (DEPTH=2).
module tb_noc_link_rx;

  logic        clk_noc = 1'b0;
  logic        rst_noc_sync;
  logic        overflow_err;
  logic [15:0] pkt_count;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  noc_link_rx_if #(.FLIT_WIDTH(64), .DEST_WIDTH(4)) u_if ();

  noc_link_rx #(
    .FLIT_WIDTH        (64),
    .DEST_WIDTH        (4),
    .FLIT_BUFFER_DEPTH (2),
    .PKT_CNT_WIDTH     (16),
    .ROUTER_FORCE_MLAB (1'b0)
  ) dut (
    .clk_noc      (clk_noc),
    .rst_noc_sync (rst_noc_sync),
    .link         (u_if.slave),
    .overflow_err (overflow_err),
    .pkt_count    (pkt_count)
  );

  always #5 clk_noc = ~clk_noc;

  task automatic step();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [3:0] dst, input logic tl);
    u_if.send_in    = 1'b1;
    u_if.data_in    = d;
    u_if.dest_in    = dst;
    u_if.is_tail_in = tl;
  endtask

  localparam logic [63:0] A = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] FA = 64'h1111_0000_0000_000A;
  localparam logic [63:0] FB = 64'h2222_0000_0000_000B;
  localparam logic [63:0] FC = 64'h3333_0000_0000_000C;
  localparam logic [63:0] FD = 64'h4444_0000_0000_000D;
  localparam logic [63:0] FE = 64'h5555_0000_0000_000E;
  localparam logic [63:0] FF = 64'h6666_0000_0000_000F;
  localparam logic [63:0] FG = 64'h7777_0000_0000_0010;
  localparam logic [63:0] FH = 64'h8888_0000_0000_0011;

  initial begin
    logic [68:0] q[$];
    logic [68:0] exp_flit;
    logic [63:0] rd;
    logic [3:0]  rdst;
    int credits, credit_total, sent, rcvd, cyc;

    rst_noc_sync         = 1'b1;
    u_if.send_in         = 1'b0;
    u_if.data_in         = '0;
    u_if.dest_in         = '0;
    u_if.is_tail_in      = 1'b0;
    u_if.axis_out_tready = 1'b0;
    step();
    step();
    chk("rst_tvalid",   u_if.axis_out_tvalid, 1'b0);
    chk("rst_credit",   u_if.credit_out, 1'b0);
    chk("rst_overflow", overflow_err, 1'b0);
    chk("rst_pkt",      pkt_count, 16'd0);
    rst_noc_sync = 1'b0;
    step();

    // Single flit with tready high: visible next cycle, credit one cycle later.
    u_if.axis_out_tready = 1'b1;
    send(A, 4'h9, 1'b1);
    step();
    u_if.send_in = 1'b0;
    chk("single_tvalid", u_if.axis_out_tvalid, 1'b1);
    chk("single_tdata",  u_if.axis_out_tdata, A);
    chk("single_tdest",  u_if.axis_out_tdest, 4'h9);
    chk("single_tlast",  u_if.axis_out_tlast, 1'b1);
    chk("single_nocred", u_if.credit_out, 1'b0);
    step();
    chk("single_credit", u_if.credit_out, 1'b1);
    chk("single_pkt",    pkt_count, 16'd1);
    chk("single_empty",  u_if.axis_out_tvalid, 1'b0);
    step();
    chk("single_credit_once", u_if.credit_out, 1'b0);

    // Stall: two flits held while tready low, then drained back-to-back.
    u_if.axis_out_tready = 1'b0;
    send(FA, 4'h1, 1'b0);
    step();
    send(FB, 4'h2, 1'b1);
    step();
    u_if.send_in = 1'b0;
    chk("stall_tvalid",  u_if.axis_out_tvalid, 1'b1);
    chk("stall_tdata",   u_if.axis_out_tdata, FA);
    chk("stall_nocred",  u_if.credit_out, 1'b0);
    step();
    chk("stall_hold",    u_if.axis_out_tdata, FA);
    chk("stall_hold_v",  u_if.axis_out_tvalid, 1'b1);
    chk("stall_nocred2", u_if.credit_out, 1'b0);
    u_if.axis_out_tready = 1'b1;
    step();
    chk("stall_b_data",  u_if.axis_out_tdata, FB);
    chk("stall_b_last",  u_if.axis_out_tlast, 1'b1);
    chk("stall_cred1",   u_if.credit_out, 1'b1);
    step();
    chk("stall_drained", u_if.axis_out_tvalid, 1'b0);
    chk("stall_cred2",   u_if.credit_out, 1'b1);
    chk("stall_pkt",     pkt_count, 16'd2);
    step();
    chk("stall_cred_end", u_if.credit_out, 1'b0);

    // Overflow: third send into a full buffer is dropped and the error sticks.
    u_if.axis_out_tready = 1'b0;
    send(FC, 4'h3, 1'b0);
    step();
    send(FD, 4'h4, 1'b0);
    step();
    chk("ovf_not_yet", overflow_err, 1'b0);
    send(FE, 4'h5, 1'b1);
    step();
    u_if.send_in = 1'b0;
    chk("ovf_set",     overflow_err, 1'b1);
    chk("ovf_head",    u_if.axis_out_tdata, FC);
    step();
    chk("ovf_sticky",  overflow_err, 1'b1);
    u_if.axis_out_tready = 1'b1;
    step();
    chk("ovf_second",  u_if.axis_out_tdata, FD);
    chk("ovf_cred1",   u_if.credit_out, 1'b1);
    step();
    chk("ovf_only2",   u_if.axis_out_tvalid, 1'b0);
    chk("ovf_cred2",   u_if.credit_out, 1'b1);
    step();
    chk("ovf_no3rd",   u_if.credit_out, 1'b0);
    chk("ovf_sticky2", overflow_err, 1'b1);
    chk("ovf_pkt",     pkt_count, 16'd2);
    rst_noc_sync = 1'b1;
    step();
    chk("ovf_rst_clear", overflow_err, 1'b0);
    chk("ovf_rst_pkt",   pkt_count, 16'd0);
    rst_noc_sync = 1'b0;

    // Full buffer with simultaneous push and pop: accepted, order preserved.
    u_if.axis_out_tready = 1'b0;
    send(FF, 4'h6, 1'b0);
    step();
    send(FG, 4'h7, 1'b0);
    step();
    u_if.axis_out_tready = 1'b1;
    send(FH, 4'h8, 1'b1);
    step();
    u_if.send_in = 1'b0;
    chk("fullpp_noerr", overflow_err, 1'b0);
    chk("fullpp_g",     u_if.axis_out_tdata, FG);
    chk("fullpp_cred",  u_if.credit_out, 1'b1);
    step();
    chk("fullpp_h",     u_if.axis_out_tdata, FH);
    chk("fullpp_h_dst", u_if.axis_out_tdest, 4'h8);
    chk("fullpp_h_v",   u_if.axis_out_tvalid, 1'b1);
    step();
    chk("fullpp_empty", u_if.axis_out_tvalid, 1'b0);
    chk("fullpp_pkt",   pkt_count, 16'd1);
    chk("fullpp_noerr2", overflow_err, 1'b0);

    // Reset with two flits buffered; a flit sent during reset is ignored.
    u_if.axis_out_tready = 1'b0;
    send(FA, 4'hA, 1'b0);
    step();
    send(FB, 4'hB, 1'b1);
    step();
    rst_noc_sync = 1'b1;
    u_if.axis_out_tready = 1'b1;
    send(FC, 4'hC, 1'b1);
    step();
    chk("rstmid_tvalid", u_if.axis_out_tvalid, 1'b0);
    chk("rstmid_credit", u_if.credit_out, 1'b0);
    chk("rstmid_pkt",    pkt_count, 16'd0);
    rst_noc_sync = 1'b0;
    u_if.send_in = 1'b0;
    step();
    chk("rstmid_tvalid2", u_if.axis_out_tvalid, 1'b0);
    chk("rstmid_credit2", u_if.credit_out, 1'b0);
    step();
    chk("rstmid_stale",   u_if.axis_out_tvalid, 1'b0);
    chk("rstmid_pkt2",    pkt_count, 16'd0);

    // Streaming: 100 4-flit packets, credit-obeying upstream, random tready.
    credits = 2;
    credit_total = 0;
    sent = 0;
    rcvd = 0;
    cyc = 0;
    while ((rcvd < 400 || credit_total < 400) && cyc < 20000) begin
      if (u_if.credit_out) begin
        credits++;
        credit_total++;
      end
      u_if.axis_out_tready = ($urandom_range(0, 1) == 1);
      if (u_if.axis_out_tvalid && u_if.axis_out_tready) begin
        chk("stream_q_nonempty", (q.size() != 0), 1'b1);
        if (q.size() != 0) begin
          exp_flit = q.pop_front();
          chk("stream_flit",
              {u_if.axis_out_tlast, u_if.axis_out_tdest, u_if.axis_out_tdata}, exp_flit);
          rcvd++;
        end
      end
      if (sent < 400 && credits > 0) begin
        rd   = {$urandom, $urandom};
        rdst = 4'($urandom_range(0, 15));
        send(rd, rdst, (sent % 4) == 3);
        q.push_back({((sent % 4) == 3), rdst, rd});
        credits--;
        sent++;
      end else begin
        u_if.send_in = 1'b0;
      end
      step();
      cyc++;
    end
    u_if.send_in = 1'b0;
    chk("stream_timeout", (cyc < 20000), 1'b1);
    chk("stream_rcvd",    rcvd, 400);
    chk("stream_credits", credit_total, 400);
    chk("stream_pkt",     pkt_count, 16'd100);
    chk("stream_noerr",   overflow_err, 1'b0);
    chk("stream_drained", u_if.axis_out_tvalid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
